// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: op class codes, operand-B select codes and FSM state encoding for the
// execute-stage sequencer.
package alu_ctrl_pkg;

    localparam logic [2:0] CLS_NOP   = 3'd0;
    localparam logic [2:0] CLS_REG   = 3'd1;
    localparam logic [2:0] CLS_IMM   = 3'd2;
    localparam logic [2:0] CLS_SHIFT = 3'd3;
    localparam logic [2:0] CLS_MUL   = 3'd4;

    localparam logic [1:0] SEL_INB   = 2'b00;
    localparam logic [1:0] SEL_IMM   = 2'b01;
    localparam logic [1:0] SEL_SHAMT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_ITER = 2'd2,
        ST_WB   = 2'd3
    } state_e;

    function automatic logic [1:0] sel_of(input logic [2:0] cls);
        return cls == CLS_IMM ? SEL_IMM : cls == CLS_SHIFT ? SEL_SHAMT : SEL_INB;
    endfunction

endpackage

// File: rtl/alu_iter_cnt.sv
// alu_iter_cnt: loadable down-counter with zero flag, counting the remaining
// iterations of a multi-cycle op.
module alu_iter_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load_i ? load_val_i : (dec_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign zero_o = cnt_q == '0;

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: execute-stage sequencer; accepts decoded ALU ops, drives operand-B select and
// function code, runs multi-cycle MUL ops and hands results to writeback with backpressure.
module alu_seq_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int ITER_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [2:0]       issue_cls,
    input  logic [3:0]       issue_func,
    input  logic [4:0]       issue_dest,
    input  logic             flush,
    output logic [1:0]       alu_sel,
    output logic [3:0]       alu_func,
    output logic             alu_cap,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [4:0]       wb_dest,
    output logic             ill_op,
    output logic [CNT_W-1:0] op_count
);

    localparam int IW = $clog2(ITER_CYCLES);

    state_e           state_q, state_d;
    logic [2:0]       cls_q, cls_d;
    logic [3:0]       func_q, func_d;
    logic [4:0]       dest_q, dest_d;
    logic [1:0]       sel_q, sel_d;
    logic             ill_q, ill_d;
    logic             wb_valid_q;
    logic [CNT_W-1:0] ops_q, ops_d;
    logic             accept, legal, is_mul, wb_done, iter_zero;

    assign issue_ready = !rst && !flush && (state_q == ST_IDLE || (state_q == ST_WB && wb_ready));
    assign accept      = issue_valid && issue_ready;
    assign legal       = issue_cls inside {CLS_NOP, CLS_REG, CLS_IMM, CLS_SHIFT, CLS_MUL};
    assign is_mul      = cls_q == CLS_MUL;
    assign wb_done     = state_q == ST_WB && wb_ready && !flush;

    alu_iter_cnt #(.W(IW)) u_iter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (state_q == ST_EXEC && is_mul && !flush),
        .dec_i      (state_q == ST_ITER && !flush),
        .load_val_i (IW'(ITER_CYCLES - 2)),
        .zero_o     (iter_zero)
    );

    // Acceptance only happens from IDLE or a draining WB, so it can take precedence over
    // the per-state transitions below.
    always_comb begin
        state_d = state_q;
        cls_d   = accept ? issue_cls  : cls_q;
        func_d  = accept ? issue_func : func_q;
        dest_d  = accept ? issue_dest : dest_q;
        if (flush)                               state_d = ST_IDLE;
        else if (accept)                         state_d = (legal && issue_cls != CLS_NOP) ? ST_EXEC : ST_IDLE;
        else if (state_q == ST_EXEC)             state_d = is_mul ? ST_ITER : ST_WB;
        else if (state_q == ST_ITER && iter_zero) state_d = ST_WB;
        else if (state_q == ST_WB && wb_ready)   state_d = ST_IDLE;
        ill_d = accept && !legal;
        sel_d = (state_d == ST_EXEC || state_d == ST_ITER) ? sel_of(cls_d) : SEL_INB;
        ops_d = (wb_done && ops_q != '1) ? ops_q + CNT_W'(1) : ops_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cls_q      <= CLS_NOP;
            func_q     <= '0;
            dest_q     <= '0;
            sel_q      <= SEL_INB;
            ill_q      <= 1'b0;
            wb_valid_q <= 1'b0;
            ops_q      <= '0;
        end else begin
            state_q    <= state_d;
            cls_q      <= cls_d;
            func_q     <= func_d;
            dest_q     <= dest_d;
            sel_q      <= sel_d;
            ill_q      <= ill_d;
            wb_valid_q <= state_d == ST_WB;
            ops_q      <= ops_d;
        end
    end

    // Capture strobe is decoded from registered state so a same-cycle flush can still veto it.
    assign alu_cap  = !flush && ((state_q == ST_EXEC && !is_mul) || (state_q == ST_ITER && iter_zero));
    assign alu_sel  = sel_q;
    assign alu_func = func_q;
    assign wb_valid = wb_valid_q;
    assign wb_dest  = dest_q;
    assign ill_op   = ill_q;
    assign op_count = ops_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed vector table for single-cycle/NOP/illegal ops plus hand-written
// sequences for MUL, backpressure, flush, reset and counter saturation.
module tb_alu_seq_ctrl;
    import alu_ctrl_pkg::*;

    logic clk = 0, rst = 1, issue_valid = 0, flush = 0, wb_ready = 0;
    logic [2:0] issue_cls = 0;
    logic [3:0] issue_func = 0;
    logic [4:0] issue_dest = 0;

    logic issue_ready, alu_cap, wb_valid, ill_op;
    logic [1:0] alu_sel;
    logic [3:0] alu_func;
    logic [4:0] wb_dest;
    logic [15:0] op_count;

    logic s_issue_ready, s_alu_cap, s_wb_valid, s_ill_op;
    logic [1:0] s_alu_sel;
    logic [3:0] s_alu_func;
    logic [4:0] s_wb_dest;
    logic [2:0] s_op_count;

    int pass_cnt = 0, total_cnt = 0, model_cnt = 0;

    alu_seq_ctrl #(.ITER_CYCLES(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_cls(issue_cls), .issue_func(issue_func), .issue_dest(issue_dest), .flush(flush),
        .alu_sel(alu_sel), .alu_func(alu_func), .alu_cap(alu_cap), .wb_valid(wb_valid),
        .wb_ready(wb_ready), .wb_dest(wb_dest), .ill_op(ill_op), .op_count(op_count)
    );

    // Narrow-counter twin driven by the same stimulus, so saturation is reachable quickly.
    alu_seq_ctrl #(.ITER_CYCLES(4), .CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(s_issue_ready),
        .issue_cls(issue_cls), .issue_func(issue_func), .issue_dest(issue_dest), .flush(flush),
        .alu_sel(s_alu_sel), .alu_func(s_alu_func), .alu_cap(s_alu_cap), .wb_valid(s_wb_valid),
        .wb_ready(wb_ready), .wb_dest(s_wb_dest), .ill_op(s_ill_op), .op_count(s_op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] cls;
        logic [3:0] func;
        logic [4:0] dest;
        logic [1:0] sel;
        logic       exec;
        logic       ill;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    task automatic issue(input logic [2:0] c, input logic [3:0] f, input logic [4:0] d);
        issue_valid = 1; issue_cls = c; issue_func = f; issue_dest = d;
    endtask

    initial begin
        vt[0] = '{CLS_IMM,   4'd3, 5'd7,  SEL_IMM,   1'b1, 1'b0};
        vt[1] = '{CLS_REG,   4'd5, 5'd3,  SEL_INB,   1'b1, 1'b0};
        vt[2] = '{CLS_SHIFT, 4'd9, 5'd31, SEL_SHAMT, 1'b1, 1'b0};
        vt[3] = '{CLS_NOP,   4'd1, 5'd2,  SEL_INB,   1'b0, 1'b0};
        vt[4] = '{3'd6,      4'd0, 5'd0,  SEL_INB,   1'b0, 1'b1};
        vt[5] = '{3'd5,      4'd4, 5'd1,  SEL_INB,   1'b0, 1'b1};
        vt[6] = '{3'd7,      4'd8, 5'd6,  SEL_INB,   1'b0, 1'b1};

        mid;
        chk("rst_ready", issue_ready, 0);
        chk("rst_sel", alu_sel, 0);
        chk("rst_func", alu_func, 0);
        chk("rst_cap", alu_cap, 0);
        chk("rst_wbv", wb_valid, 0);
        chk("rst_dest", wb_dest, 0);
        chk("rst_ill", ill_op, 0);
        chk("rst_cnt", op_count, 0);
        step;
        rst = 0;
        wb_ready = 1;
        step;

        for (int i = 0; i < 7; i++) begin
            issue(vt[i].cls, vt[i].func, vt[i].dest);
            mid; chk("v_ready0", issue_ready, 1); step;
            issue_valid = 0;
            mid;
            chk("v_sel", alu_sel, vt[i].sel);
            chk("v_cap", alu_cap, vt[i].exec);
            chk("v_ill", ill_op, vt[i].ill);
            chk("v_wbv1", wb_valid, 0);
            chk("v_ready1", issue_ready, !vt[i].exec);
            if (vt[i].exec) chk("v_func", alu_func, vt[i].func);
            step;
            mid;
            chk("v_wbv2", wb_valid, vt[i].exec);
            if (vt[i].exec) chk("v_dest", wb_dest, vt[i].dest);
            chk("v_ill2", ill_op, 0);
            chk("v_cap2", alu_cap, 0);
            step;
            if (vt[i].exec) model_cnt++;
            mid;
            chk("v_wbv3", wb_valid, 0);
            chk("v_cnt", op_count, model_cnt);
            step;
        end

        // MUL: four execute cycles, capture on the last, writeback on the fifth
        issue(CLS_MUL, 4'd2, 5'd9);
        step;
        issue_valid = 0;
        for (int k = 1; k <= 4; k++) begin
            mid;
            chk("mul_sel", alu_sel, SEL_INB);
            chk("mul_func", alu_func, 2);
            chk("mul_cap", alu_cap, k == 4);
            chk("mul_wbv", wb_valid, 0);
            step;
        end
        mid; chk("mul_wbv5", wb_valid, 1); chk("mul_dest", wb_dest, 9); step;
        model_cnt++;
        mid; chk("mul_wbv6", wb_valid, 0); chk("mul_cnt", op_count, model_cnt); step;

        // SHIFT then REG with writeback stalled for three cycles
        wb_ready = 0;
        issue(CLS_SHIFT, 4'd1, 5'd4);
        step;
        issue(CLS_REG, 4'd6, 5'd12);
        mid; chk("bp_sel", alu_sel, SEL_SHAMT); chk("bp_cap", alu_cap, 1); chk("bp_rdy_ex", issue_ready, 0); step;
        for (int k = 0; k < 3; k++) begin
            mid;
            chk("bp_wbv", wb_valid, 1);
            chk("bp_dest", wb_dest, 4);
            chk("bp_ready", issue_ready, 0);
            step;
        end
        wb_ready = 1;
        mid; chk("bp_rdy_rise", issue_ready, 1); chk("bp_wbv_rise", wb_valid, 1); step;
        issue_valid = 0;
        model_cnt++;
        mid;
        chk("bp2_sel", alu_sel, SEL_INB);
        chk("bp2_cap", alu_cap, 1);
        chk("bp2_func", alu_func, 6);
        chk("bp2_wbv", wb_valid, 0);
        chk("bp2_cnt", op_count, model_cnt);
        step;
        mid; chk("bp2_wbv2", wb_valid, 1); chk("bp2_dest", wb_dest, 12); step;
        model_cnt++;
        mid; chk("bp2_wbv3", wb_valid, 0); chk("bp2_cnt2", op_count, model_cnt); step;

        // flush on the MUL capture cycle
        issue(CLS_MUL, 4'd2, 5'd9);
        step;
        issue_valid = 0;
        step; step; step;
        flush = 1;
        issue(CLS_REG, 4'd5, 5'd3);
        mid; chk("fl_cap", alu_cap, 0); chk("fl_ready", issue_ready, 0); step;
        flush = 0;
        issue_valid = 0;
        mid;
        chk("fl_wbv", wb_valid, 0);
        chk("fl_sel", alu_sel, SEL_INB);
        chk("fl_cnt", op_count, model_cnt);
        chk("fl_ready2", issue_ready, 1);
        step;
        mid; chk("fl_wbv2", wb_valid, 0); step;

        // flush while writeback is being consumed: result dropped
        issue(CLS_IMM, 4'd3, 5'd5);
        step;
        issue_valid = 0;
        step;
        flush = 1;
        issue(CLS_REG, 4'd5, 5'd3);
        mid; chk("fw_ready", issue_ready, 0); chk("fw_wbv", wb_valid, 1); step;
        flush = 0;
        issue_valid = 0;
        mid; chk("fw_wbv2", wb_valid, 0); chk("fw_cnt", op_count, model_cnt); chk("fw_cap", alu_cap, 0); step;

        // asynchronous reset while a result waits in writeback
        wb_ready = 0;
        issue(CLS_REG, 4'd4, 5'd11);
        step;
        issue_valid = 0;
        step;
        mid; chk("ar_wbv_pre", wb_valid, 1); chk("ar_cnt_pre", op_count, model_cnt);
        rst = 1;
        #1;
        chk("ar_wbv", wb_valid, 0);
        chk("ar_dest", wb_dest, 0);
        chk("ar_func", alu_func, 0);
        chk("ar_sel", alu_sel, 0);
        chk("ar_cap", alu_cap, 0);
        chk("ar_cnt", op_count, 0);
        chk("ar_ready", issue_ready, 0);
        model_cnt = 0;
        step;
        rst = 0;
        wb_ready = 1;
        step;

        // saturation of the narrow counter
        for (int n = 1; n <= 9; n++) begin
            issue(CLS_REG, 4'd1, 5'd1);
            step;
            issue_valid = 0;
            step; step;
            model_cnt++;
            mid;
            chk("sat_cnt", s_op_count, (model_cnt > 7) ? 7 : model_cnt);
            step;
        end
        chk("sat_main", op_count, model_cnt);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
